coin_credit_ctrl: RTL

Credit accumulator and vend/change controller for the mini vending machine. Sits directly downstream of the coin keypad interface. Consumes its 3-bit coin-code pulses, keeps a running credit in cents, and handles product select and cancel. Issues a one-cycle vend pulse and returns change through a valid/ack handshake to the display/dispenser stage.

---
 rtl/vm_pkg.sv | 13 +
 rtl/coin_credit_ctrl_if.sv | 23 ++
 rtl/coin_value_decode.sv | 13 +
 rtl/coin_credit_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: shared coin codes, coin values, credit width and controller state set
package vm_pkg;
    localparam int CREDIT_W = 8;
    localparam logic [2:0] COIN_DOLLAR  = 3'b101;
    localparam logic [2:0] COIN_QUARTER = 3'b110;
    localparam logic [2:0] COIN_DIME    = 3'b011;
    localparam logic [2:0] COIN_NONE    = 3'b111;
    localparam logic [CREDIT_W-1:0] VAL_DOLLAR  = 8'd100;
    localparam logic [CREDIT_W-1:0] VAL_QUARTER = 8'd25;
    localparam logic [CREDIT_W-1:0] VAL_DIME    = 8'd10;
    typedef logic [CREDIT_W-1:0] credit_t;
    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_e;
endpackage

// File: rtl/coin_credit_ctrl_if.sv
// coin_credit_ctrl_if: keypad-side inputs and display/dispenser-side outputs of the credit controller
interface coin_credit_ctrl_if;
    import vm_pkg::*;
    logic [2:0] i_coin;
    logic       i_select;
    logic       i_cancel;
    logic       i_change_ack;
    credit_t    o_credit;
    logic       o_vend;
    credit_t    o_change;
    logic       o_change_valid;
    logic       o_coin_reject;
    logic       o_insufficient;
    logic       o_busy;
    modport slave (
        input  i_coin, i_select, i_cancel, i_change_ack,
        output o_credit, o_vend, o_change, o_change_valid, o_coin_reject, o_insufficient, o_busy
    );
    modport master (
        output i_coin, i_select, i_cancel, i_change_ack,
        input  o_credit, o_vend, o_change, o_change_valid, o_coin_reject, o_insufficient, o_busy
    );
endinterface

// File: rtl/coin_value_decode.sv
// coin_value_decode: maps a keypad coin code to its value in cents and a valid flag
module coin_value_decode
    import vm_pkg::*;
(
    input  logic [2:0] i_code,
    output credit_t    o_value,
    output logic       o_valid
);
    assign o_value = (i_code == COIN_DOLLAR)  ? VAL_DOLLAR  :
                     (i_code == COIN_QUARTER) ? VAL_QUARTER :
                     (i_code == COIN_DIME)    ? VAL_DIME    : '0;
    assign o_valid = (i_code == COIN_DOLLAR) || (i_code == COIN_QUARTER) || (i_code == COIN_DIME);
endmodule

// File: rtl/coin_credit_ctrl.sv
// coin_credit_ctrl: credit accumulator with select/cancel handling, vend pulse and change handshake
module coin_credit_ctrl
    import vm_pkg::*;
#(
    parameter int PRICE      = 125,
    parameter int MAX_CREDIT = 250
) (
    input logic i_clk,
    input logic i_rst_n,
    coin_credit_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_CREDIT = CREDIT;
    localparam logic [1:0] ST_VEND   = VEND;
    localparam logic [1:0] ST_CHANGE = CHANGE;
    localparam logic [CREDIT_W:0] C_PRICE = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W:0] C_MAX   = (CREDIT_W+1)'(MAX_CREDIT);

    logic [1:0]      r_state;
    logic [2:0]      r_prev;
    credit_t         r_credit;
    credit_t         r_change;
    logic            r_change_valid;
    logic            r_vend;
    logic            r_reject;
    logic            r_insuff;

    logic [1:0]      w_state;
    credit_t         w_credit;
    credit_t         w_change;
    logic            w_change_valid;
    logic            w_vend;
    logic            w_reject;
    logic            w_insuff;
    credit_t         w_value;
    logic            w_valid;
    logic            w_coin_ev;
    logic [CREDIT_W:0] w_sum;

    coin_value_decode u_dec (
        .i_code  (bus.i_coin),
        .o_value (w_value),
        .o_valid (w_valid)
    );

    // a coin counts only on the first cycle of a valid code after an idle (none) code
    assign w_coin_ev = w_valid && (r_prev == COIN_NONE);
    // one extra bit so the ceiling check happens before the credit could wrap
    assign w_sum     = {1'b0, r_credit} + {1'b0, w_value};

    // next-state and next-output decision; cancel beats select beats coin in IDLE/CREDIT
    always_comb begin
        w_state        = r_state;
        w_credit       = r_credit;
        w_change       = r_change;
        w_change_valid = r_change_valid;
        w_vend         = 1'b0;
        w_reject       = 1'b0;
        w_insuff       = 1'b0;
        case (r_state)
            ST_VEND: begin
                w_reject = w_coin_ev;
                if (r_credit != '0) begin
                    w_state        = ST_CHANGE;
                    w_change       = r_credit;
                    w_change_valid = 1'b1;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                w_reject = w_coin_ev;
                if (bus.i_change_ack) begin
                    w_state        = ST_IDLE;
                    w_credit       = '0;
                    w_change       = '0;
                    w_change_valid = 1'b0;
                end
            end
            default: begin
                if (bus.i_cancel && r_state == ST_CREDIT) begin
                    w_state        = ST_CHANGE;
                    w_change       = r_credit;
                    w_change_valid = 1'b1;
                    w_reject       = w_coin_ev;
                end else if (bus.i_select && {1'b0, r_credit} >= C_PRICE) begin
                    w_state  = ST_VEND;
                    w_vend   = 1'b1;
                    w_credit = r_credit - C_PRICE[CREDIT_W-1:0];
                    w_reject = w_coin_ev;
                end else begin
                    w_insuff = bus.i_select;
                    if (w_coin_ev) begin
                        if (w_sum <= C_MAX) begin
                            w_credit = w_sum[CREDIT_W-1:0];
                            w_state  = ST_CREDIT;
                        end else begin
                            w_reject = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // register state, credit and every output; reset discards any pending change
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_prev         <= COIN_NONE;
            r_credit       <= '0;
            r_change       <= '0;
            r_change_valid <= 1'b0;
            r_vend         <= 1'b0;
            r_reject       <= 1'b0;
            r_insuff       <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_prev         <= bus.i_coin;
            r_credit       <= w_credit;
            r_change       <= w_change;
            r_change_valid <= w_change_valid;
            r_vend         <= w_vend;
            r_reject       <= w_reject;
            r_insuff       <= w_insuff;
        end
    end

    assign bus.o_credit       = r_credit;
    assign bus.o_vend         = r_vend;
    assign bus.o_change       = r_change;
    assign bus.o_change_valid = r_change_valid;
    assign bus.o_coin_reject  = r_reject;
    assign bus.o_insufficient = r_insuff;
    assign bus.o_busy         = (r_state == ST_VEND) || (r_state == ST_CHANGE);
endmodule
